// File: rtl/mem_bus_if_if.sv
// Bundle of control-side request signals and external memory bus signals.
// Latency: none, wiring only.
// Backpressure: the slave drives oRdy to hold control and waits on iBusAck from the bus.
interface mem_bus_if_if;
  logic        iRead;
  logic        iWrite;
  logic [31:0] iAddr;
  logic [31:0] iWData;
  logic [31:0] oRData;
  logic        oRdy;
  logic [31:0] oBusAddr;
  logic [31:0] oBusWData;
  logic        oBusRd;
  logic        oBusWr;
  logic [31:0] iBusData;
  logic        iBusAck;
  logic        oFault;

  // Interface block view: requests and bus responses in, data/strobes/status out.
  modport slave (
    input  iRead, iWrite, iAddr, iWData, iBusData, iBusAck,
    output oRData, oRdy, oBusAddr, oBusWData, oBusRd, oBusWr, oFault
  );

  // Environment view: control unit plus memory bus.
  modport master (
    output iRead, iWrite, iAddr, iWData, iBusData, iBusAck,
    input  oRData, oRdy, oBusAddr, oBusWData, oBusRd, oBusWr, oFault
  );
endinterface

// File: rtl/mem_bus_if.sv
// Memory bus interface: one acknowledged bus transaction per control read/write request.
// Latency: request to ready is 2 cycles minimum (IDLE -> ACCESS -> DONE), plus wait states.
// Backpressure: oRdy low holds the control step counter until the bus acknowledges.
// Optional MEMIF_TIMEOUT_EN: aborts ACCESS after TIMEOUT cycles, flags oFault, reads return all-ones.
module mem_bus_if #(
  parameter int MIN_WAIT = 0,
  parameter int TIMEOUT  = 255
) (
  input logic        iClk,
  input logic        nRst,
  mem_bus_if_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        req;
  logic        is_wr;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [3:0]  wait_cnt;
  logic        fault_q;

  logic        wait_ok;
  logic        ack_ok;
  logic        tmo_hit;
  logic        rdy;
  logic        bus_rd;
  logic        bus_wr;

  // Reject out-of-range configurations at elaboration.
  if (MIN_WAIT < 0 || MIN_WAIT > 15) begin : g_min_wait_range
    $error("mem_bus_if: MIN_WAIT out of range");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("mem_bus_if: TIMEOUT out of range");
  end

  assign req = bus.iRead | bus.iWrite;

  // With no minimum wait every ack in ACCESS is honoured; otherwise gate on the wait counter.
  if (MIN_WAIT == 0) begin : g_no_wait
    assign wait_ok = 1'b1;
  end else begin : g_wait
    assign wait_ok = (wait_cnt >= 4'(MIN_WAIT));
  end

  assign ack_ok = (state == ACCESS) && bus.iBusAck && wait_ok;

`ifdef MEMIF_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  // Count ACCESS cycles; the final allowed cycle without an honoured ack forces DONE.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      tmo_cnt <= 8'd0;
    end else if (state == ACCESS) begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end else begin
      tmo_cnt <= 8'd0;
    end
  end

  assign tmo_hit = (state == ACCESS) && !ack_ok && (tmo_cnt == 8'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // State register; async reset returns to IDLE so strobes drop immediately.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-state outputs; requests are only sampled in IDLE.
  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    bus_rd    = 1'b0;
    bus_wr    = 1'b0;
    case (state)
      IDLE: begin
        rdy = !req;
        if (req) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        bus_rd = !is_wr;
        bus_wr = is_wr;
        if (ack_ok || tmo_hit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        rdy       = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request latching, wait counting, read-data capture and sticky fault.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      is_wr    <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      wait_cnt <= 4'd0;
      fault_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            addr_q   <= bus.iAddr;
            wdata_q  <= bus.iWData;
            is_wr    <= bus.iWrite;
            wait_cnt <= 4'd0;
            if (bus.iRead && bus.iWrite) begin
              fault_q <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (wait_cnt != 4'hF) begin
            wait_cnt <= wait_cnt + 4'd1;
          end
          if (ack_ok) begin
            if (!is_wr) begin
              rdata_q <= bus.iBusData;
            end
          end else if (tmo_hit) begin
            fault_q <= 1'b1;
            if (!is_wr) begin
              rdata_q <= 32'hFFFF_FFFF;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.oRdy      = rdy;
  assign bus.oBusRd    = bus_rd;
  assign bus.oBusWr    = bus_wr;
  assign bus.oBusAddr  = addr_q;
  assign bus.oBusWData = wdata_q;
  assign bus.oRData    = rdata_q;
  assign bus.oFault    = fault_q;

endmodule

// File: tb/tb_mem_bus_if.sv
// Directed bench for mem_bus_if: instance A with no wait states, instance B with MIN_WAIT=3.
// Latency: checks sampled 1-2 ns after the rising edge.
// Backpressure: every wait on oRdy is bounded by a cycle budget.
module tb_mem_bus_if;
  logic iClk;
  logic nRst;
  int   passed;
  int   total;
  int   rd_n;
  int   wr_n;
  int   both_n;
  int   got_rdy;

  mem_bus_if_if bus_a ();
  mem_bus_if_if bus_b ();

  mem_bus_if #(.MIN_WAIT(0), .TIMEOUT(8)) dut_a (.iClk(iClk), .nRst(nRst), .bus(bus_a));
  mem_bus_if #(.MIN_WAIT(3), .TIMEOUT(8)) dut_b (.iClk(iClk), .nRst(nRst), .bus(bus_b));

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Run instance B until it reports ready, counting strobe cycles.
  task automatic run_b();
    rd_n = 0; wr_n = 0; both_n = 0; got_rdy = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus_b.oRdy) begin
        got_rdy = 1;
        break;
      end
      if (bus_b.oBusRd) rd_n++;
      if (bus_b.oBusWr) wr_n++;
      if (bus_b.oBusRd && bus_b.oBusWr) both_n++;
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    nRst   = 1'b1;
    bus_a.iRead = 0; bus_a.iWrite = 0; bus_a.iAddr = 0; bus_a.iWData = 0;
    bus_a.iBusData = 0; bus_a.iBusAck = 0;
    bus_b.iRead = 0; bus_b.iWrite = 0; bus_b.iAddr = 0; bus_b.iWData = 0;
    bus_b.iBusData = 0; bus_b.iBusAck = 0;
    #1 nRst = 1'b0;
    #2;
    chk1 ("rst_rdy",    bus_a.oRdy, 1'b1);
    chk32("rst_rdata",  bus_a.oRData, 32'h0);
    chk1 ("rst_busrd",  bus_a.oBusRd, 1'b0);
    chk1 ("rst_buswr",  bus_a.oBusWr, 1'b0);
    chk32("rst_addr",   bus_a.oBusAddr, 32'h0);
    chk32("rst_wdata",  bus_a.oBusWData, 32'h0);
    chk1 ("rst_fault",  bus_a.oFault, 1'b0);
    chk1 ("rst_rdy_b",  bus_b.oRdy, 1'b1);
    repeat (2) @(negedge iClk);
    nRst = 1'b1;
    step();

    // Zero-wait read
    bus_a.iRead = 1; bus_a.iAddr = 32'h40; bus_a.iWData = 32'h55;
    #1;
    chk1 ("rd_rdy_req", bus_a.oRdy, 1'b0);
    step();
    chk1 ("rd_busrd",   bus_a.oBusRd, 1'b1);
    chk1 ("rd_buswr",   bus_a.oBusWr, 1'b0);
    chk32("rd_addr",    bus_a.oBusAddr, 32'h40);
    chk1 ("rd_rdy_acc", bus_a.oRdy, 1'b0);
    bus_a.iBusAck = 1; bus_a.iBusData = 32'hDEADBEEF;
    step();
    chk1 ("rd_rdy_done", bus_a.oRdy, 1'b1);
    chk32("rd_rdata",    bus_a.oRData, 32'hDEADBEEF);
    chk1 ("rd_busrd_dn", bus_a.oBusRd, 1'b0);
    bus_a.iRead = 0; bus_a.iBusAck = 0;
    step();
    chk1 ("rd_rdy_idle", bus_a.oRdy, 1'b1);
    chk32("rd_hold",     bus_a.oRData, 32'hDEADBEEF);
    chk32("rd_addrhold", bus_a.oBusAddr, 32'h40);

    // Back-to-back read then write, write strobe rising in DONE
    bus_a.iRead = 1; bus_a.iAddr = 32'h44;
    step();
    chk1 ("b2b_rd", bus_a.oBusRd, 1'b1);
    bus_a.iBusAck = 1; bus_a.iBusData = 32'hCAFEF00D;
    step();
    chk1 ("b2b_rdy1",  bus_a.oRdy, 1'b1);
    chk32("b2b_rdata", bus_a.oRData, 32'hCAFEF00D);
    bus_a.iRead = 0; bus_a.iWrite = 1; bus_a.iAddr = 32'h48; bus_a.iWData = 32'h0BADC0DE;
    bus_a.iBusAck = 0;
    #1;
    chk1 ("b2b_rdy_dn", bus_a.oRdy, 1'b1);
    chk1 ("b2b_wr_dn",  bus_a.oBusWr, 1'b0);
    step();
    chk1 ("b2b_rdy_idle", bus_a.oRdy, 1'b0);
    chk1 ("b2b_wr_idle",  bus_a.oBusWr, 1'b0);
    chk1 ("b2b_rd_idle",  bus_a.oBusRd, 1'b0);
    step();
    chk1 ("b2b_wr",     bus_a.oBusWr, 1'b1);
    chk1 ("b2b_wr_rd",  bus_a.oBusRd, 1'b0);
    chk32("b2b_waddr",  bus_a.oBusAddr, 32'h48);
    chk32("b2b_wdata",  bus_a.oBusWData, 32'h0BADC0DE);
    bus_a.iBusAck = 1; bus_a.iBusData = 32'h11111111;
    step();
    chk1 ("b2b_rdy2",   bus_a.oRdy, 1'b1);
    chk32("b2b_keep",   bus_a.oRData, 32'hCAFEF00D);
    bus_a.iWrite = 0; bus_a.iBusAck = 0;
    step();
    chk1 ("b2b_rdy_end", bus_a.oRdy, 1'b1);

    // Instance B: read then write with ack held high throughout
    bus_b.iRead = 1; bus_b.iAddr = 32'h10; bus_b.iBusAck = 1; bus_b.iBusData = 32'hA5A5A5A5;
    run_b();
    chkn ("w3_rd_done",  got_rdy, 1);
    chkn ("w3_rd_cyc",   rd_n, 4);
    chk32("w3_rd_data",  bus_b.oRData, 32'hA5A5A5A5);
    bus_b.iRead = 0;
    step();
    bus_b.iWrite = 1; bus_b.iAddr = 32'h80; bus_b.iWData = 32'h12345678;
    bus_b.iBusData = 32'h99999999;
    run_b();
    chkn ("w3_wr_done",  got_rdy, 1);
    chkn ("w3_wr_cyc",   wr_n, 4);
    chkn ("w3_wr_rd",    rd_n, 0);
    chkn ("w3_overlap",  both_n, 0);
    chk32("w3_wdata",    bus_b.oBusWData, 32'h12345678);
    chk32("w3_waddr",    bus_b.oBusAddr, 32'h80);
    chk32("w3_rkeep",    bus_b.oRData, 32'hA5A5A5A5);
    bus_b.iWrite = 0; bus_b.iBusAck = 0;
    step();

    // Reset in the middle of an access
    bus_a.iRead = 1; bus_a.iAddr = 32'h200;
    step(); step(); step();
    chk1 ("mid_busrd", bus_a.oBusRd, 1'b1);
    #2 nRst = 1'b0;
    #1;
    chk1 ("mid_rd_drop", bus_a.oBusRd, 1'b0);
    chk32("mid_addr",    bus_a.oBusAddr, 32'h0);
    chk32("mid_rdata",   bus_a.oRData, 32'h0);
    chk1 ("mid_fault",   bus_a.oFault, 1'b0);
    bus_a.iRead = 0;
    #1;
    chk1 ("mid_rdy",     bus_a.oRdy, 1'b1);
    @(negedge iClk);
    nRst = 1'b1;
    bus_a.iRead = 1; bus_a.iAddr = 32'h300;
    step();
    chk1 ("post_busrd", bus_a.oBusRd, 1'b1);
    chk32("post_addr",  bus_a.oBusAddr, 32'h300);
    bus_a.iBusAck = 1; bus_a.iBusData = 32'h600DD00D;
    step();
    chk1 ("post_rdy",   bus_a.oRdy, 1'b1);
    chk32("post_rdata", bus_a.oRData, 32'h600DD00D);
    bus_a.iRead = 0; bus_a.iBusAck = 0;
    step();

    // Read with no ack: timeout when enabled, otherwise waits indefinitely
    bus_a.iRead = 1; bus_a.iAddr = 32'h400;
    rd_n = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (bus_a.oRdy) break;
      if (bus_a.oBusRd) rd_n++;
    end
`ifdef MEMIF_TIMEOUT_EN
    chkn ("tmo_cycles", rd_n, 8);
    chk1 ("tmo_rdy",    bus_a.oRdy, 1'b1);
    chk32("tmo_rdata",  bus_a.oRData, 32'hFFFFFFFF);
    chk1 ("tmo_fault",  bus_a.oFault, 1'b1);
`else
    chkn ("wait_cycles", rd_n, 1000);
    chk1 ("wait_rdy",    bus_a.oRdy, 1'b0);
    chk1 ("wait_busrd",  bus_a.oBusRd, 1'b1);
    chk1 ("wait_fault",  bus_a.oFault, 1'b0);
`endif
    bus_a.iRead = 0;
    nRst = 1'b0;
    #3 nRst = 1'b1;
    step();
    chk1 ("tmo_clr_fault", bus_a.oFault, 1'b0);

    // Simultaneous read and write strobes: write wins, fault is sticky
    bus_a.iRead = 1; bus_a.iWrite = 1; bus_a.iAddr = 32'h500; bus_a.iWData = 32'hFEEDFACE;
    #1;
    chk1 ("sim_rdy_req", bus_a.oRdy, 1'b0);
    step();
    chk1 ("sim_buswr",  bus_a.oBusWr, 1'b1);
    chk1 ("sim_busrd",  bus_a.oBusRd, 1'b0);
    chk1 ("sim_fault",  bus_a.oFault, 1'b1);
    chk32("sim_wdata",  bus_a.oBusWData, 32'hFEEDFACE);
    bus_a.iBusAck = 1; bus_a.iBusData = 32'h77777777;
    step();
    chk1 ("sim_rdy",    bus_a.oRdy, 1'b1);
    chk32("sim_rkeep",  bus_a.oRData, 32'h0);
    bus_a.iRead = 0; bus_a.iWrite = 0; bus_a.iBusAck = 0;
    step(); step(); step();
    chk1 ("sim_sticky", bus_a.oFault, 1'b1);
    nRst = 1'b0;
    #1;
    chk1 ("sim_rst_clr", bus_a.oFault, 1'b0);
    nRst = 1'b1;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_bus_if.md
# mem_bus_if

Memory bus interface between the multi-cycle control unit and the external memory bus. It accepts the level-sensitive read/write strobes and address/data from the datapath, runs one acknowledged bus transaction per request, and returns read data. It generates the ready signal that gates the control step counter, so a step that touches memory holds until the bus completes.

## Interface

**Parameters**
- `MIN_WAIT`, default 0: minimum number of cycles spent in ACCESS before `iBusAck` is honoured, range 0–15.
- `TIMEOUT`, default 255: ACCESS cycles before abort. Only used with `MEMIF_TIMEOUT_EN`; range 1–255.

**Ports**
- `iClk`  in  1  clock.
- `nRst`  in  1  reset, asynchronous, active-low.
- `iRead`  in  1  read request strobe, level, from control.
- `iWrite`  in  1  write request strobe, level, from control.
- `iAddr`  in  32  byte address from the address-select mux.
- `iWData`  in  32  store data.
- `oRData`  out  32  read data to the instruction register and write-back mux.
- `oRdy`  out  1  step-advance permission to control.
- `oBusAddr`  out  32  registered bus address.
- `oBusWData`  out  32  registered bus write data.
- `oBusRd`  out  1  bus read strobe.
- `oBusWr`  out  1  bus write strobe.
- `iBusData`  in  32  bus read data.
- `iBusAck`  in  1  bus acknowledge, single-cycle.
- `oFault`  out  1  sticky error flag.

## Operation

- **Request:** `req = iRead | iWrite`.
- **Write priority:** if `iRead` and `iWrite` are high together, the transaction is a write and `oFault` is set.
- **FSM states:** IDLE, ACCESS, DONE.
  - **IDLE:** if `req`, latch `iAddr`, `iWData` and the type (read/write), clear the wait counter, and go to ACCESS. Otherwise stay in IDLE.
  - **ACCESS:**
    - `oBusRd` or `oBusWr` is high according to the latched type.
    - The wait counter increments each cycle, saturating at 15.
    - If `iBusAck` is high and counter ≥ `MIN_WAIT`: on a read, latch `iBusData` into the read-data register; then go to DONE.
    - `iBusAck` is ignored while counter < `MIN_WAIT`.
  - **DONE:** go to IDLE unconditionally. Bus strobes are low.
- **`oRdy`** is combinational:
  - 1 in DONE.
  - 1 in IDLE with `req` = 0.
  - 0 otherwise. This includes IDLE with `req` = 1, so control cannot advance during the same cycle a request appears.
- **Back-to-back requests:** the strobe is still high in the IDLE cycle after DONE only if the next step also accesses memory. That case starts a new transaction; no request is ever serviced twice within one step.
- **`oRData`:** driven from the read-data register at all times. It holds its value until the next completed read.
- **Write-only transactions** do not modify the read-data register.
- **Bus outputs:**
  - `oBusAddr` and `oBusWData` hold their latched values outside ACCESS.
  - `oBusRd` and `oBusWr` are never high together.
- **`oFault`:** set by a simultaneous read/write request, or by a timeout (see Configuration). Cleared only by reset.

## Timing

- **Reset values:**
  - State IDLE.
  - `oBusRd` = 0, `oBusWr` = 0.
  - `oBusAddr` = 0, `oBusWData` = 0.
  - Read-data register = 0, so `oRData` = 0.
  - `oFault` = 0, counters = 0.
  - `oRdy` = 1 when no request is present.
- **Latency:** request seen in IDLE at cycle *t*; ACCESS from *t*+1; with ack at cycle *a*, DONE at *a*+1, where `oRdy` = 1 and `oRData` is valid.
  - Minimum request-to-ready is 2 cycles (`MIN_WAIT` = 0, ack in the first ACCESS cycle).
- **Ack outside ACCESS:** ignored.
- **Reset mid-transaction:** bus strobes drop asynchronously and the transaction is abandoned; no partial data is kept.
- **Request dropped during ACCESS:** the transaction still completes. The strobe is not re-sampled until IDLE.

## Configuration

- **`MEMIF_TIMEOUT_EN` defined:**
  - A timeout counter runs during ACCESS.
  - After `TIMEOUT` ACCESS cycles with no honoured ack, the FSM goes to DONE and sets `oFault`.
  - On a read timeout, the read-data register loads `32'hFFFF_FFFF`.
- **`MEMIF_TIMEOUT_EN` undefined:** no timeout logic; ACCESS waits indefinitely for `iBusAck`.

## Test plan

- **Zero-wait read:** `iRead` = 1, `iAddr` = 0x40, ack in the first ACCESS cycle with `iBusData` = 0xDEADBEEF → `oBusRd` high for 1 cycle, `oBusAddr` = 0x40, `oRdy` = 1 two cycles after the request, `oRData` = 0xDEADBEEF.
- **Write with wait states:** `MIN_WAIT` = 3, `iWrite` = 1, `iWData` = 0x12345678, ack held high throughout → `oBusWr` high for exactly 4 cycles, `oBusWData` = 0x12345678, `oRData` unchanged.
- **Back-to-back:** a read followed immediately by a write whose strobe rises in the DONE cycle → two distinct transactions, strobes never overlap, `oRdy` pulses once per transaction.
- **Simultaneous strobes:** `iRead` = `iWrite` = 1 → a write transaction is issued and `oFault` = 1 and stays 1 until `nRst`.
- **Timeout:** with `MEMIF_TIMEOUT_EN` defined, `TIMEOUT` = 8, read with no ack → DONE after 8 ACCESS cycles, `oRData` = 0xFFFFFFFF, `oFault` = 1. Without the macro → still in ACCESS after 1000 cycles.
- **Reset mid-access:** `nRst` low during ACCESS → `oBusRd` drops the same cycle, all outputs at reset values, and a request after release starts cleanly.
